// File: rtl/alu_result_arbiter_pkg.sv
// Shared constants for the ALU result bus arbiter: state codes, requester count, widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_result_arbiter_pkg;

  // Requester count and the width of an index into it
  localparam int NREQ = 8;
  localparam int SELW = 3;

  // Default result width, shared with the ALU datapath
  localparam int DW_DEF = 12;

  // Sequencer states
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // One-hot decode of a requester index
  function automatic logic [NREQ-1:0] onehot8(input logic [SELW-1:0] idx);
    onehot8 = NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_result_arbiter_rr_pick8.sv
// Round-robin picker (rr_pick8) plus the 8:1 result mux (Mux_8_1) it steers.
// Latency: purely combinational, zero cycles.
// Backpressure: none; callers decide when the pick is consumed.
module rr_pick8
  import alu_result_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx,
  output logic [NREQ-1:0] onehot
);

  // Search ptr+1, ptr+2, ... wrapping mod 8; ptr itself is tried last
  always_comb begin
    logic [SELW-1:0] cand;
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int o = 1; o <= NREQ; o++) begin
      cand = ptr + SELW'(o);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

  assign onehot = any ? onehot8(idx) : '0;

endmodule

module Mux_8_1 #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] y
);

  // Plain 8:1 select
  always_comb begin
    case (s)
      3'd0:    y = i0;
      3'd1:    y = i1;
      3'd2:    y = i2;
      3'd3:    y = i3;
      3'd4:    y = i4;
      3'd5:    y = i5;
      3'd6:    y = i6;
      default: y = i7;
    endcase
  end

endmodule

// File: rtl/alu_result_arbiter.sv
// Round-robin arbiter/sequencer for eight ALU result sources onto one valid/ready bus.
// Latency: grant + registered data one cycle after req seen in IDLE; ack one cycle after accept.
// Backpressure: out_ready low holds grant/data frozen; optional ARB_LOCK_EN adds bounded lock.
module alu_result_arbiter
  import alu_result_arbiter_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      req,
  input  logic [DW-1:0]   d0,
  input  logic [DW-1:0]   d1,
  input  logic [DW-1:0]   d2,
  input  logic [DW-1:0]   d3,
  input  logic [DW-1:0]   d4,
  input  logic [DW-1:0]   d5,
  input  logic [DW-1:0]   d6,
  input  logic [DW-1:0]   d7,
  input  logic [7:0]      lock,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      sel,
  output logic [7:0]      gnt,
  output logic [7:0]      ack
);

  logic            state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;

  logic            pick_any;
  logic [SELW-1:0] pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic [DW-1:0]   mux_y;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  Mux_8_1 #(.WIDTH(DW)) u_mux (
    .i0 (d0), .i1 (d1), .i2 (d2), .i3 (d3),
    .i4 (d4), .i5 (d5), .i6 (d6), .i7 (d7),
    .s  (pick_idx),
    .y  (mux_y)
  );

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_hold;
  assign lock_hold = lock[sel_q] && req[sel_q] && (cnt_q < CW'(LOCK_MAX - 1));
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // Next-state: IDLE captures a new winner, BUSY waits for the consumer to accept
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ack_d       = '0;
`ifdef ARB_LOCK_EN
    cnt_d       = cnt_q;
`endif
    if (state_q == ST_IDLE) begin
      if (pick_any) begin
        gnt_d       = pick_onehot;
        sel_d       = pick_idx;
        out_data_d  = mux_y;
        out_valid_d = 1'b1;
        state_d     = ST_BUSY;
      end else begin
        gnt_d       = '0;
        out_valid_d = 1'b0;
      end
    end else if (out_valid_q && out_ready) begin
      ack_d       = onehot8(sel_q);
      gnt_d       = '0;
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
      ptr_d       = sel_q;
`ifdef ARB_LOCK_EN
      // Park ptr just behind the locked requester so it is searched first again
      if (lock_hold) begin
        ptr_d = sel_q - SELW'(1);
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
`endif
    end
  end

  // State registers; reset drops any in-flight transfer without an ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= SELW'(NREQ - 1);
      sel_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef ARB_LOCK_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef ARB_LOCK_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign ack       = ack_q;

endmodule

// File: tb/tb_alu_result_arbiter.sv
// Directed bench for alu_result_arbiter with hand-computed expectations.
// Latency: drives 1 time unit after each rising edge and checks right there.
// Backpressure: exercises out_ready low holds and a mid-transfer reset.
module tb_alu_result_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req;
  logic [7:0]  lock;
  logic        out_ready;
  logic [11:0] dv [8];
  logic        out_valid;
  logic [11:0] out_data;
  logic [2:0]  sel;
  logic [7:0]  gnt;
  logic [7:0]  ack;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_result_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (dv[0]), .d1 (dv[1]), .d2 (dv[2]), .d3 (dv[3]),
    .d4        (dv[4]), .d5 (dv[5]), .d6 (dv[6]), .d7 (dv[7]),
    .lock      (lock),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input int k, input logic [11:0] dexp);
    check_eq({tag, " valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, " sel"},   32'(sel),       32'(k));
    check_eq({tag, " gnt"},   32'(gnt),       32'(8'd1 << k));
    check_eq({tag, " data"},  32'(out_data),  32'(dexp));
    check_eq({tag, " noack"}, 32'(ack),       32'd0);
  endtask

  task automatic check_ack(input string tag, input int k);
    check_eq({tag, " ack"},     32'(ack),       32'(8'd1 << k));
    check_eq({tag, " valid0"},  32'(out_valid), 32'd0);
    check_eq({tag, " gnt0"},    32'(gnt),       32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, " valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, " gnt"},   32'(gnt),       32'd0);
    check_eq({tag, " ack"},   32'(ack),       32'd0);
  endtask

  int lock_seq [7];

  initial begin
`ifdef ARB_LOCK_EN
    lock_seq = '{1, 2, 2, 2, 2, 1, 2};
`else
    lock_seq = '{1, 2, 1, 2, 1, 2, 1};
`endif
    for (int i = 0; i < 8; i++) dv[i] = 12'h100 * 12'(i) + 12'h0A0 + 12'(i);
    rst_n = 1'b0; req = 8'hFF; lock = 8'h00; out_ready = 1'b1;

    // Reset holds everything at zero even with all requests high
    tick(); tick();
    check_quiet("reset");
    check_eq("reset sel",  32'(sel),      32'd0);
    check_eq("reset data", 32'(out_data), 32'd0);

    // First grant after reset goes to requester 0
    rst_n = 1'b1;
    tick(); check_grant("first", 0, 12'h0A0);
    req = 8'h00;
    tick(); check_ack("first", 0);
    tick(); check_quiet("idle");

    // Single request from requester 3
    dv[3] = 12'hABC; req = 8'h08;
    tick(); check_grant("single", 3, 12'hABC);
    tick(); check_ack("single", 3);
    req = 8'h00;
    tick(); check_quiet("single after");

    // Full contention from a fresh pointer: 0..7 then 0 again
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    dv[3] = 12'h3A3; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick(); check_grant($sformatf("rr%0d", i), i % 8, 12'h100 * 12'(i % 8) + 12'h0A0 + 12'(i % 8));
      tick(); check_ack($sformatf("rr%0d", i), i % 8);
    end
    req = 8'h00; tick();

    // Backpressure: data frozen at capture while the source changes
    out_ready = 1'b0; req = 8'h20; dv[5] = 12'h111;
    tick(); check_grant("bp cap", 5, 12'h111);
    dv[5] = 12'h222;
    for (int i = 0; i < 5; i++) begin
      tick(); check_grant($sformatf("bp hold%0d", i), 5, 12'h111);
    end
    out_ready = 1'b1;
    tick(); check_ack("bp", 5);
    req = 8'h00; tick();

    // Reset during a stalled transfer drops it; requester 0 then wins
    out_ready = 1'b0; req = 8'h41;
    tick(); check_grant("mid busy", 6, 12'h6A6);
    rst_n = 1'b0;
    tick(); check_quiet("mid reset");
    check_eq("mid reset sel", 32'(sel), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick(); check_grant("mid after", 0, 12'h0A0);
    tick(); check_ack("mid after", 0);
    req = 8'h00; tick();

    // Lock: requester 2 locked, contending with requester 1
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 8'h06; lock = 8'h04;
    for (int i = 0; i < 7; i++) begin
      tick(); check_grant($sformatf("lock%0d", i), lock_seq[i],
                          12'h100 * 12'(lock_seq[i]) + 12'h0A0 + 12'(lock_seq[i]));
      tick(); check_ack($sformatf("lock%0d", i), lock_seq[i]);
    end
    req = 8'h00; lock = 8'h00; tick();
    check_quiet("end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_result_arbiter.md
Name: alu_result_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 12-bit ALU result bus; eight requesters share one output.
- Grants one requester at a time and drives the select of the existing 8:1 result mux.
- Captures the selected data into an output register and presents it to a single consumer with a valid/ready handshake.
- Acknowledges the granted requester when the consumer accepts the transfer.

Parameters:
- DW, 12, data width of each requester and of the output bus.
- LOCK_MAX, 4, maximum consecutive grants to one locked requester; used only with ARB_LOCK_EN.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  8  request per requester; held high until matching ack.
- d0..d7  input  DW each  requester data.
- lock  input  8  per-requester lock request; ignored unless ARB_LOCK_EN.
- out_ready  input  1  consumer ready.
- out_valid  output  1  output data valid.
- out_data  output  DW  captured data of the granted requester.
- sel  output  3  index of the current/last grant; drives the mux select.
- gnt  output  8  one-hot grant; zero when idle.
- ack  output  8  one-cycle one-hot pulse on transfer acceptance.

Behaviour:
- Reset (rst_n low at a clk edge): gnt=0, sel=0, out_valid=0, out_data=0, ack=0, ptr=7, state=IDLE, lock count=0. Reset overrides all other activity, including mid-transfer. An in-flight transfer is dropped and no ack is issued.
- States: IDLE and BUSY.
- IDLE behaviour:
  - If req is nonzero, pick the first set bit searching ptr+1, ptr+2, … with mod-8 wrap.
  - Register gnt=onehot(k), sel=k, out_data=d[k], out_valid=1, state=BUSY.
  - If req is zero, stay IDLE with gnt=0 and out_valid=0.
- BUSY behaviour:
  - Hold gnt, sel, out_data and out_valid stable while out_ready=0. out_data does not track later changes on d[k].
  - On out_valid && out_ready: ack[sel]=1 for exactly that next cycle, ptr=sel, gnt=0, out_valid=0, state=IDLE.
  - If req[k] drops while BUSY, the transfer still completes and ack is still pulsed.
- Latency: req seen in IDLE at edge N gives out_valid high after edge N. ack pulses the cycle after acceptance.
- Throughput: at most one transfer per 2 cycles; a 1-cycle IDLE bubble is mandatory between grants.
- Fairness:
  - ptr advances only on acceptance.
  - A requester is re-granted only after every other active requester has been served once.
  - Starvation-free when ARB_LOCK_EN is off.
- Invariants: gnt is zero or one-hot; when gnt is nonzero, gnt equals onehot(sel); ack is zero or one-hot.
- ptr wraps 7→0. A single requester is re-granted every 2 cycles.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - On acceptance, if lock[sel] && req[sel] && cnt < LOCK_MAX-1, then ptr is not advanced, cnt increments, and the same requester wins the next IDLE cycle.
  - Otherwise cnt=0 and ptr=sel as normal.
  - A requester therefore holds at most LOCK_MAX consecutive grants.
- Not defined: the lock input is ignored, no counter logic is built, and behaviour is pure round-robin.

Decomposition:
- Shared package / header holds:
  - state encodings: ST_IDLE=1'b0, ST_BUSY=1'b1;
  - constants NREQ=8 and SELW=3;
  - the DW default of 12, shared with the ALU datapath.
- The natural sub-module is rr_pick8: combinational; inputs req[7:0] and ptr[2:0]; outputs any, idx[2:0] and onehot[7:0].
- The data selection instantiates the existing Mux_8_1, with s tied to the next-grant index.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=8'hFF → all outputs 0. After release, the first grant is requester 0 (ptr=7).
- Single request: req=8'h08, d3=12'hABC, out_ready=1:
  - cycle+1: out_valid=1, sel=3, gnt=8'h08, out_data=12'hABC;
  - cycle+2: ack=8'h08, out_valid=0.
- Full contention: req=8'hFF held and out_ready=1 → grants in order 0,1,…,7,0, one every 2 cycles, each with a matching ack.
- Backpressure: req=8'h20, out_ready=0 for 5 cycles while d5 changes 12'h111→12'h222 → out_data stays 12'h111 and ack=0. Raising out_ready gives ack=8'h20 on the next cycle.
- Mid-transfer reset: rst_n=0 while BUSY with out_ready=0 → next cycle all outputs 0, no ack, and requester 0 has priority afterwards.
- Lock (ARB_LOCK_EN, LOCK_MAX=4): req=8'h06, lock=8'h04 → grant sequence 1,2,2,2,2,1,2,… Without the macro the sequence alternates 1,2,1,2.
